cp0_exc_commit: RTL and testbench

//  Commit-stage CP0 block: consumes the exception record produced by the last exception-carrying pipeline stage.

---
 rtl/cp0_exc_commit.sv | 214 +++++++++++++++++++++
 tb/tb_cp0_exc_commit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_commit.sv
// cp0_exc_commit: commit-stage CP0 block.
// It holds Status, Cause, EPC and BadVAddr, and optionally Count and Compare.
// It decides exception, interrupt and ERET redirection, and it serves MTC0/MFC0.
// Build option: define CP0_TIMER_EN to include the Count/Compare timer and the TI interrupt.
// Without that macro, registers 9 and 11 read 0, writes to them are ignored, and TI stays 0.
// Handshake: there is no stall path.
// A record is consumed in the cycle in which commit_valid=1. It is accepted unconditionally.
// exc_occur and exc_target are valid in that same cycle.
// Every register update lands on the following clock edge.
module cp0_exc_commit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [31:0] pc,
  input  logic [31:0] badvaddr,
  input  logic [4:0]  exc_code,
  input  logic        is_exc,
  input  logic        is_in_ds,
  input  logic        is_eret,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  output logic        exc_occur,
  output logic [31:0] exc_target,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_epc
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Architectural state. Only the implemented bits are stored.
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [5:0]  hw_int_q;

  logic        ti;
  logic [31:0] count_val;
  logic [31:0] compare_val;

  logic [7:0]  ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        int_req;
  logic        take;
  logic [4:0]  take_code;
  logic        eret_go;
  logic        mtc0_go;

  // Assemble the visible register images and the redirect decision.
  always_comb begin
    ip         = {hw_int_q[5] | ti, hw_int_q[4:0], ip_sw_q};
    status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    cause_val  = {bd_q, ti, 14'b0, ip, 1'b0, code_q, 2'b0};
    int_req    = ie_q & ~exl_q & (|(ip & im_q));
    take       = commit_valid & (int_req | is_exc);
    // An interrupt claims the retiring instruction and overrides its exception code.
    take_code  = int_req ? 5'd0 : exc_code;
    eret_go    = commit_valid & is_eret & ~take;
    // A trapping instruction must not retire its MTC0.
    mtc0_go    = mtc0_we & commit_valid & ~take;
    exc_occur  = take | eret_go;
    exc_target = take ? EXC_VECTOR : epc_q;
    cp0_status = status_val;
    cp0_epc    = epc_q;
  end

  // Next-state for Status, Cause, EPC and BadVAddr.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    code_d     = code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (mtc0_go) begin
      case (mtc0_addr)
        REG_STATUS: begin
          im_d  = mtc0_wdata[15:8];
          exl_d = mtc0_wdata[1];
          ie_d  = mtc0_wdata[0];
        end
        REG_CAUSE: ip_sw_d = mtc0_wdata[9:8];
        REG_EPC:   epc_d   = mtc0_wdata;
        default:   ;
      endcase
    end
    if (take) begin
      code_d = take_code;
      exl_d  = 1'b1;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = pc;
        bd_d  = is_in_ds;
      end
      if (take_code == 5'd4 || take_code == 5'd5) begin
        badvaddr_d = badvaddr;
      end
    end else if (eret_go) begin
      exl_d = 1'b0;
    end
  end

  // Register the CP0 state and sample the interrupt lines every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= RESET_STATUS[15:8];
      exl_q      <= RESET_STATUS[1];
      ie_q       <= RESET_STATUS[0];
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b0;
      code_q     <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      hw_int_q   <= 6'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      hw_int_q   <= hw_int;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        ti_q, ti_d;
  logic        count_step;

  // Count advances every second cycle.
  // TI is raised only when Count actually changes onto Compare.
  // Because of that, the reset state Count=Compare=0 does not fire.
  always_comb begin
    toggle_d   = ~toggle_q;
    count_d    = count_q + {31'b0, toggle_q};
    count_step = toggle_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    if (mtc0_go && mtc0_addr == REG_COUNT) begin
      count_d    = mtc0_wdata;
      toggle_d   = 1'b0;
      count_step = 1'b1;
    end
    if (mtc0_go && mtc0_addr == REG_COMPARE) begin
      compare_d = mtc0_wdata;
      ti_d      = 1'b0;
    end else if (count_step && count_d == compare_q) begin
      ti_d = 1'b1;
    end
  end

  // Register the timer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      ti_q      <= ti_d;
    end
  end

  assign ti          = ti_q;
  assign count_val   = count_q;
  assign compare_val = compare_q;
`else
  assign ti          = 1'b0;
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
`endif

  // MFC0 read mux. It shows pre-edge values, and unmapped numbers read 0.
  always_comb begin
    mfc0_rdata = 32'd0;
    case (mfc0_addr)
      REG_BADVADDR: mfc0_rdata = badvaddr_q;
      REG_COUNT:    mfc0_rdata = count_val;
      REG_COMPARE:  mfc0_rdata = compare_val;
      REG_STATUS:   mfc0_rdata = status_val;
      REG_CAUSE:    mfc0_rdata = cause_val;
      REG_EPC:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_commit.sv
// Directed testbench for cp0_exc_commit.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are checked after a further settle delay, well before the next edge.
module tb_cp0_exc_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] pc;
  logic [31:0] badvaddr;
  logic [4:0]  exc_code;
  logic        is_exc;
  logic        is_in_ds;
  logic        is_eret;
  logic [5:0]  hw_int;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        exc_occur;
  logic [31:0] exc_target;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  cp0_exc_commit dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .pc(pc),
    .badvaddr(badvaddr), .exc_code(exc_code), .is_exc(is_exc),
    .is_in_ds(is_in_ds), .is_eret(is_eret), .hw_int(hw_int),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata), .exc_occur(exc_occur),
    .exc_target(exc_target), .cp0_status(cp0_status), .cp0_epc(cp0_epc)
  );

  // Clock and run-time guard
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    commit_valid = 1'b0; pc = 32'd0; badvaddr = 32'd0; exc_code = 5'd0;
    is_exc = 1'b0; is_in_ds = 1'b0; is_eret = 1'b0;
    mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_wdata = 32'd0;
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] p,
                           input logic [31:0] b, input logic ds);
    commit_valid = 1'b1; is_exc = 1'b1; exc_code = code;
    pc = p; badvaddr = b; is_in_ds = ds;
  endtask

  task automatic drive_mtc0(input logic [4:0] a, input logic [31:0] d, input logic cv);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d; commit_valid = cv;
  endtask

  task automatic drive_eret;
    commit_valid = 1'b1; is_eret = 1'b1;
  endtask

  // Scenario tasks
  task automatic test_reset;
    reset = 1'b1; idle(); hw_int = 6'd0; mfc0_addr = 5'd0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h exp %h", cp0_status, 32'h0040_0000); end
    checks++; if (cp0_epc !== 32'd0) begin errors++; $display("FAIL reset_epc got %h exp %h", cp0_epc, 32'd0); end
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL reset_exc_occur got %b exp 0", exc_occur); end
    mfc0_addr = 5'd12; #1;
    checks++; if (mfc0_rdata !== 32'h0040_0000) begin errors++; $display("FAIL reset_mfc0_12 got %h exp %h", mfc0_rdata, 32'h0040_0000); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL reset_mfc0_13 got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd14; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL reset_mfc0_14 got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd8; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL reset_mfc0_8 got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd9; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL reset_mfc0_9 got %h exp 0", mfc0_rdata); end
  endtask

  task automatic test_exc_adel;
    drive_exc(5'd4, 32'hBFC0_0100, 32'h1234_5671, 1'b0); #1;
    checks++; if (exc_occur !== 1'b1) begin errors++; $display("FAIL adel_occur got %b exp 1", exc_occur); end
    checks++; if (exc_target !== 32'hBFC0_0380) begin errors++; $display("FAIL adel_target got %h exp %h", exc_target, 32'hBFC0_0380); end
    tick(); idle(); #1;
    checks++; if (cp0_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL adel_epc got %h exp %h", cp0_epc, 32'hBFC0_0100); end
    checks++; if (cp0_status !== 32'h0040_0002) begin errors++; $display("FAIL adel_status got %h exp %h", cp0_status, 32'h0040_0002); end
    mfc0_addr = 5'd8; #1;
    checks++; if (mfc0_rdata !== 32'h1234_5671) begin errors++; $display("FAIL adel_badvaddr got %h exp %h", mfc0_rdata, 32'h1234_5671); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'h0000_0010) begin errors++; $display("FAIL adel_cause got %h exp %h", mfc0_rdata, 32'h0000_0010); end
  endtask

  task automatic test_nested;
    drive_exc(5'd10, 32'hBFC0_0300, 32'hDEAD_0000, 1'b1); #1;
    checks++; if (exc_occur !== 1'b1 || exc_target !== 32'hBFC0_0380) begin errors++; $display("FAIL nested_redirect got %b/%h exp 1/%h", exc_occur, exc_target, 32'hBFC0_0380); end
    tick(); idle(); #1;
    checks++; if (cp0_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL nested_epc_held got %h exp %h", cp0_epc, 32'hBFC0_0100); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'h0000_0028) begin errors++; $display("FAIL nested_cause got %h exp %h", mfc0_rdata, 32'h0000_0028); end
    mfc0_addr = 5'd8; #1;
    checks++; if (mfc0_rdata !== 32'h1234_5671) begin errors++; $display("FAIL nested_badvaddr_held got %h exp %h", mfc0_rdata, 32'h1234_5671); end
  endtask

  task automatic test_eret;
    drive_mtc0(5'd14, 32'hBFC0_0200, 1'b1);
    tick(); idle(); #1;
    checks++; if (cp0_epc !== 32'hBFC0_0200) begin errors++; $display("FAIL eret_epc_write got %h exp %h", cp0_epc, 32'hBFC0_0200); end
    drive_eret(); #1;
    checks++; if (exc_occur !== 1'b1) begin errors++; $display("FAIL eret_occur got %b exp 1", exc_occur); end
    checks++; if (exc_target !== 32'hBFC0_0200) begin errors++; $display("FAIL eret_target got %h exp %h", exc_target, 32'hBFC0_0200); end
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL eret_exl_clear got %h exp %h", cp0_status, 32'h0040_0000); end
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL eret_idle_occur got %b exp 0", exc_occur); end
  endtask

  task automatic test_mtc0_dropped;
    drive_exc(5'd12, 32'h8000_1000, 32'h0, 1'b1);
    mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0000_FF01; #1;
    checks++; if (exc_occur !== 1'b1) begin errors++; $display("FAIL drop_occur got %b exp 1", exc_occur); end
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0002) begin errors++; $display("FAIL drop_status got %h exp %h", cp0_status, 32'h0040_0002); end
    checks++; if (cp0_epc !== 32'h8000_1000) begin errors++; $display("FAIL drop_epc got %h exp %h", cp0_epc, 32'h8000_1000); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'h8000_0030) begin errors++; $display("FAIL drop_cause_bd got %h exp %h", mfc0_rdata, 32'h8000_0030); end
    drive_eret(); #1;
    checks++; if (exc_target !== 32'h8000_1000) begin errors++; $display("FAIL drop_eret_target got %h exp %h", exc_target, 32'h8000_1000); end
    tick(); idle(); #1;
  endtask

  task automatic test_mtc0_fields;
    drive_mtc0(5'd12, 32'hFFFF_FFFF, 1'b0);
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL fields_nocommit got %h exp %h", cp0_status, 32'h0040_0000); end
    drive_mtc0(5'd12, 32'hFFFF_FFFF, 1'b1);
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_FF03) begin errors++; $display("FAIL fields_status_mask got %h exp %h", cp0_status, 32'h0040_FF03); end
    drive_mtc0(5'd13, 32'hFFFF_FFFF, 1'b1);
    tick(); idle(); mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'h8000_0330) begin errors++; $display("FAIL fields_cause_mask got %h exp %h", mfc0_rdata, 32'h8000_0330); end
    drive_mtc0(5'd13, 32'h0, 1'b1);
    tick(); idle(); #1;
    checks++; if (mfc0_rdata !== 32'h8000_0030) begin errors++; $display("FAIL fields_cause_clear got %h exp %h", mfc0_rdata, 32'h8000_0030); end
    drive_mtc0(5'd8, 32'h0, 1'b1);
    tick(); idle(); mfc0_addr = 5'd8; #1;
    checks++; if (mfc0_rdata !== 32'h1234_5671) begin errors++; $display("FAIL fields_badvaddr_ro got %h exp %h", mfc0_rdata, 32'h1234_5671); end
    drive_mtc0(5'd12, 32'h0, 1'b1);
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL fields_status_clear got %h exp %h", cp0_status, 32'h0040_0000); end
  endtask

  task automatic test_hw_int;
    drive_mtc0(5'd12, 32'h0000_0401, 1'b1);
    tick(); idle(); hw_int = 6'b000001;
    tick(); mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'h8000_0430) begin errors++; $display("FAIL hwint_ip got %h exp %h", mfc0_rdata, 32'h8000_0430); end
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL hwint_no_commit got %b exp 0", exc_occur); end
    drive_exc(5'd8, 32'h8000_2000, 32'h0, 1'b0); #1;
    checks++; if (exc_occur !== 1'b1 || exc_target !== 32'hBFC0_0380) begin errors++; $display("FAIL hwint_take got %b/%h exp 1/%h", exc_occur, exc_target, 32'hBFC0_0380); end
    tick(); idle(); #1;
    checks++; if (mfc0_rdata !== 32'h0000_0400) begin errors++; $display("FAIL hwint_code0 got %h exp %h", mfc0_rdata, 32'h0000_0400); end
    checks++; if (cp0_epc !== 32'h8000_2000) begin errors++; $display("FAIL hwint_epc got %h exp %h", cp0_epc, 32'h8000_2000); end
    checks++; if (cp0_status !== 32'h0040_0403) begin errors++; $display("FAIL hwint_status got %h exp %h", cp0_status, 32'h0040_0403); end
    commit_valid = 1'b1; #1;
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL hwint_masked_exl got %b exp 0", exc_occur); end
    tick(); idle(); hw_int = 6'd0; drive_eret(); #1;
    checks++; if (exc_target !== 32'h8000_2000) begin errors++; $display("FAIL hwint_eret_target got %h exp %h", exc_target, 32'h8000_2000); end
    tick(); idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0401) begin errors++; $display("FAIL hwint_after_eret got %h exp %h", cp0_status, 32'h0040_0401); end
    drive_mtc0(5'd12, 32'h0, 1'b1);
    tick(); idle(); #1;
  endtask

  task automatic test_back_to_back;
    mfc0_addr = 5'd14;
    drive_mtc0(5'd14, 32'h1111_0000, 1'b1);
    exp_q.push_back(32'h8000_2000); #1;
    exp_v = exp_q.pop_front();
    checks++; if (mfc0_rdata !== exp_v) begin errors++; $display("FAIL b2b_read0 got %h exp %h", mfc0_rdata, exp_v); end
    tick();
    drive_mtc0(5'd14, 32'h2222_0000, 1'b1);
    exp_q.push_back(32'h1111_0000); #1;
    exp_v = exp_q.pop_front();
    checks++; if (mfc0_rdata !== exp_v) begin errors++; $display("FAIL b2b_read1 got %h exp %h", mfc0_rdata, exp_v); end
    tick(); idle();
    exp_q.push_back(32'h2222_0000); #1;
    exp_v = exp_q.pop_front();
    checks++; if (mfc0_rdata !== exp_v) begin errors++; $display("FAIL b2b_read2 got %h exp %h", mfc0_rdata, exp_v); end
    mfc0_addr = 5'd15; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL unmapped_15 got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd10; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL unmapped_10 got %h exp 0", mfc0_rdata); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer;
    drive_mtc0(5'd11, 32'd10, 1'b1);
    tick(); drive_mtc0(5'd9, 32'd0, 1'b1);
    tick(); drive_mtc0(5'd12, 32'h0000_8001, 1'b1); mfc0_addr = 5'd9; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL timer_count_load got %h exp 0", mfc0_rdata); end
    tick(); idle();
    for (int i = 0; i < 18; i++) tick();
    #1;
    checks++; if (mfc0_rdata !== 32'd9) begin errors++; $display("FAIL timer_count_19 got %h exp 9", mfc0_rdata); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_early got %b exp 0", mfc0_rdata[30]); end
    tick(); #1;
    checks++; if (mfc0_rdata !== 32'h4000_8000) begin errors++; $display("FAIL timer_ti_set got %h exp %h", mfc0_rdata, 32'h4000_8000); end
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL timer_no_commit got %b exp 0", exc_occur); end
    commit_valid = 1'b1; pc = 32'h8000_3000; #1;
    checks++; if (exc_occur !== 1'b1 || exc_target !== 32'hBFC0_0380) begin errors++; $display("FAIL timer_take got %b/%h exp 1/%h", exc_occur, exc_target, 32'hBFC0_0380); end
    tick(); idle(); #1;
    checks++; if (cp0_epc !== 32'h8000_3000) begin errors++; $display("FAIL timer_epc got %h exp %h", cp0_epc, 32'h8000_3000); end
    checks++; if (cp0_status !== 32'h0040_8003) begin errors++; $display("FAIL timer_status got %h exp %h", cp0_status, 32'h0040_8003); end
    drive_mtc0(5'd11, 32'd1000, 1'b1);
    tick(); idle(); #1;
    checks++; if (mfc0_rdata !== 32'h0000_0000) begin errors++; $display("FAIL timer_ti_clear got %h exp 0", mfc0_rdata); end
    drive_eret(); tick(); idle();
    drive_mtc0(5'd12, 32'h0, 1'b1); tick(); idle(); #1;
  endtask
`else
  task automatic test_timer;
    drive_mtc0(5'd9, 32'd5, 1'b1);
    tick(); drive_mtc0(5'd11, 32'd5, 1'b1);
    tick(); idle();
    for (int i = 0; i < 12; i++) tick();
    mfc0_addr = 5'd9; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL notimer_count got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd11; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL notimer_compare got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata[30] !== 1'b0) begin errors++; $display("FAIL notimer_ti got %b exp 0", mfc0_rdata[30]); end
  endtask
`endif

  task automatic test_reset_wins;
    drive_exc(5'd5, 32'h8000_4000, 32'hCAFE_BABE, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0; idle(); #1;
    checks++; if (cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL rstwin_status got %h exp %h", cp0_status, 32'h0040_0000); end
    checks++; if (cp0_epc !== 32'd0) begin errors++; $display("FAIL rstwin_epc got %h exp 0", cp0_epc); end
    checks++; if (exc_occur !== 1'b0) begin errors++; $display("FAIL rstwin_occur got %b exp 0", exc_occur); end
    mfc0_addr = 5'd8; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL rstwin_badvaddr got %h exp 0", mfc0_rdata); end
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_rdata !== 32'd0) begin errors++; $display("FAIL rstwin_cause got %h exp 0", mfc0_rdata); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_exc_adel();
    test_nested();
    test_eret();
    test_mtc0_dropped();
    test_mtc0_fields();
    test_hw_int();
    test_back_to_back();
    test_timer();
    test_reset_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
